// File: rtl/nco_sine_lut_if.sv
// nco_sine_lut_if: control and sample bus of the sine/cosine NCO.
//   en        : advance accumulator and launch one sample
//   sync_clr  : synchronous accumulator clear
//   freq_we   : load tuning word from freq_in
//   freq_in   : unsigned tuning word
//   phase_off : phase offset added ahead of table lookup
//   out_valid : sin_out/cos_out carry a new sample
//   sin_out   : signed sine sample
//   cos_out   : signed cosine sample
interface nco_sine_lut_if #(
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 16
);
   logic                 en;
   logic                 sync_clr;
   logic                 freq_we;
   logic [ACC_WIDTH-1:0] freq_in;
   logic [ACC_WIDTH-1:0] phase_off;
   logic                 out_valid;
   logic [OUT_WIDTH-1:0] sin_out;
   logic [OUT_WIDTH-1:0] cos_out;

   modport master (
      output en, sync_clr, freq_we, freq_in, phase_off,
      input  out_valid, sin_out, cos_out
   );

   modport slave (
      input  en, sync_clr, freq_we, freq_in, phase_off,
      output out_valid, sin_out, cos_out
   );
endinterface

// File: rtl/nco_sine_lut.sv
// nco_sine_lut: numerically controlled oscillator with a quarter-wave sine
// table, producing registered signed sine and cosine samples three clocks
// after each enabled accumulator step.
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nco_sine_lut_if (control in, samples out)
module nco_sine_lut #(
   parameter int ACC_WIDTH = 32,
   parameter int LUT_ADDR  = 8,
   parameter int OUT_WIDTH = 16
) (
   input logic            clk,
   input logic            rst_n,
   nco_sine_lut_if.slave  bus
);

   localparam int  ROM_DEPTH = 2 ** LUT_ADDR;
   localparam int  PH_SHIFT  = ACC_WIDTH - LUT_ADDR - 2;
   localparam real PI        = 3.14159265358979323846;

   if (ACC_WIDTH < LUT_ADDR + 2) begin : g_bad_width
      $fatal(1, "nco_sine_lut: ACC_WIDTH must be >= LUT_ADDR+2");
   end

   // Sample points sit half an index into each step so that entry[~i]
   // is exactly the quarter-wave mirror of entry[i].
   function automatic logic [OUT_WIDTH-1:0] rom_entry(input int k);
      real amp;
      real x;
      amp = (2.0 ** (OUT_WIDTH - 1)) - 1.0;
      x   = amp * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(ROM_DEPTH));
      return OUT_WIDTH'($rtoi(x + 0.5));
   endfunction

   logic [OUT_WIDTH-1:0] rom [ROM_DEPTH];

   for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
      assign rom[k] = rom_entry(k);
   end

   // Tuning word and accumulator
   logic [ACC_WIDTH-1:0] freq_q, freq_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;

   // Stage 1: quadrant and index of the sampled phase
   logic                 s1_v_q, s1_v_d;
   logic [1:0]           s1_quad_q, s1_quad_d;
   logic [LUT_ADDR-1:0]  s1_idx_q, s1_idx_d;
   logic [LUT_ADDR+1:0]  phase_top;

   // Stage 2: folded table address and sign per path
   logic                 s2_v_q, s2_v_d;
   logic [LUT_ADDR-1:0]  s2_sin_addr_q, s2_sin_addr_d;
   logic [LUT_ADDR-1:0]  s2_cos_addr_q, s2_cos_addr_d;
   logic                 s2_sin_neg_q, s2_sin_neg_d;
   logic                 s2_cos_neg_q, s2_cos_neg_d;
   logic [1:0]           cos_quad;

   // Stage 3: outputs
   logic                 out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0] sin_q, sin_d;
   logic [OUT_WIDTH-1:0] cos_q, cos_d;

   // Only the top LUT_ADDR+2 bits of the offset phase are ever looked at.
   assign phase_top = (LUT_ADDR + 2)'((acc_q + bus.phase_off) >> PH_SHIFT);
   assign cos_quad  = s1_quad_q + 2'd1;

   always_comb begin
      freq_d = bus.freq_we ? bus.freq_in : freq_q;

      acc_d = acc_q;
      if (bus.sync_clr) begin
         acc_d = '0;
      end else if (bus.en) begin
         acc_d = acc_q + freq_q;
      end

      s1_v_d    = bus.en;
      s1_quad_d = s1_quad_q;
      s1_idx_d  = s1_idx_q;
      if (bus.en) begin
         s1_quad_d = phase_top[LUT_ADDR+1:LUT_ADDR];
         s1_idx_d  = phase_top[LUT_ADDR-1:0];
      end

      s2_v_d        = s1_v_q;
      s2_sin_addr_d = s2_sin_addr_q;
      s2_cos_addr_d = s2_cos_addr_q;
      s2_sin_neg_d  = s2_sin_neg_q;
      s2_cos_neg_d  = s2_cos_neg_q;
      if (s1_v_q) begin
         // Odd quadrants walk the quarter table backwards.
         s2_sin_addr_d = s1_quad_q[0] ? ~s1_idx_q : s1_idx_q;
         s2_cos_addr_d = cos_quad[0]  ? ~s1_idx_q : s1_idx_q;
         s2_sin_neg_d  = s1_quad_q[1];
         s2_cos_neg_d  = cos_quad[1];
      end

      out_valid_d = s2_v_q;
      sin_d       = sin_q;
      cos_d       = cos_q;
      if (s2_v_q) begin
         sin_d = s2_sin_neg_q ? -rom[s2_sin_addr_q] : rom[s2_sin_addr_q];
         cos_d = s2_cos_neg_q ? -rom[s2_cos_addr_q] : rom[s2_cos_addr_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq_q        <= '0;
         acc_q         <= '0;
         s1_v_q        <= 1'b0;
         s1_quad_q     <= '0;
         s1_idx_q      <= '0;
         s2_v_q        <= 1'b0;
         s2_sin_addr_q <= '0;
         s2_cos_addr_q <= '0;
         s2_sin_neg_q  <= 1'b0;
         s2_cos_neg_q  <= 1'b0;
         out_valid_q   <= 1'b0;
         sin_q         <= '0;
         cos_q         <= '0;
      end else begin
         freq_q        <= freq_d;
         acc_q         <= acc_d;
         s1_v_q        <= s1_v_d;
         s1_quad_q     <= s1_quad_d;
         s1_idx_q      <= s1_idx_d;
         s2_v_q        <= s2_v_d;
         s2_sin_addr_q <= s2_sin_addr_d;
         s2_cos_addr_q <= s2_cos_addr_d;
         s2_sin_neg_q  <= s2_sin_neg_d;
         s2_cos_neg_q  <= s2_cos_neg_d;
         out_valid_q   <= out_valid_d;
         sin_q         <= sin_d;
         cos_q         <= cos_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sin_out   = sin_q;
   assign bus.cos_out   = cos_q;

endmodule

// File: tb/tb_nco_sine_lut.sv
// tb_nco_sine_lut: self-checking bench for nco_sine_lut at default widths.
// A phase-domain model predicts every output each cycle; directed scenarios
// add literal expectations for the known table points.
module tb_nco_sine_lut;

   localparam real PI = 3.14159265358979323846;

   logic clk;
   logic rst_n;

   nco_sine_lut_if #(.ACC_WIDTH(32), .OUT_WIDTH(16)) bus ();

   nco_sine_lut #(
      .ACC_WIDTH (32),
      .LUT_ADDR  (8),
      .OUT_WIDTH (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Ideal sine of the 1024-step phase circle, sampled mid-step.
   function automatic int ref_sine(input logic [31:0] p);
      int  n;
      real v;
      n = int'(p >> 22);
      v = 32767.0 * $sin(2.0 * PI * (real'(n) + 0.5) / 1024.0);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] m_acc, m_freq;
   logic        pv0, pv1;
   int          ps0, ps1, pc0, pc1;
   logic        e_valid;
   int          e_sin, e_cos;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_acc <= '0; m_freq <= '0;
         pv0 <= 1'b0; pv1 <= 1'b0;
         ps0 <= 0; ps1 <= 0; pc0 <= 0; pc1 <= 0;
         e_valid <= 1'b0; e_sin <= 0; e_cos <= 0;
      end else begin
         e_valid <= pv1;
         if (pv1) begin
            e_sin <= ps1;
            e_cos <= pc1;
         end
         pv1 <= pv0; ps1 <= ps0; pc1 <= pc0;
         pv0 <= bus.en;
         if (bus.en) begin
            ps0 <= ref_sine(m_acc + bus.phase_off);
            pc0 <= ref_sine(m_acc + bus.phase_off + 32'h4000_0000);
         end
         if (bus.sync_clr)  m_acc <= '0;
         else if (bus.en)   m_acc <= m_acc + m_freq;
         if (bus.freq_we)   m_freq <= bus.freq_in;
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      checks = checks + 3;
      if (bus.out_valid !== e_valid) begin
         errors = errors + 1;
         $display("FAIL out_valid t=%0t got %0b expected %0b", $time, bus.out_valid, e_valid);
      end
      if (int'($signed(bus.sin_out)) != e_sin || $isunknown(bus.sin_out)) begin
         errors = errors + 1;
         $display("FAIL sin_out t=%0t got %0d expected %0d", $time, $signed(bus.sin_out), e_sin);
      end
      if (int'($signed(bus.cos_out)) != e_cos || $isunknown(bus.cos_out)) begin
         errors = errors + 1;
         $display("FAIL cos_out t=%0t got %0d expected %0d", $time, $signed(bus.cos_out), e_cos);
      end
   end

   task automatic check_lit(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic int s_out();
      return int'($signed(bus.sin_out));
   endfunction

   function automatic int c_out();
      return int'($signed(bus.cos_out));
   endfunction

   task automatic idle();
      bus.en = 1'b0; bus.sync_clr = 1'b0; bus.freq_we = 1'b0;
   endtask

   // Clear acc and load a new tuning word, pipeline drained afterwards.
   task automatic restart(input logic [31:0] f, input logic [31:0] ph);
      idle();
      bus.sync_clr = 1'b1; bus.freq_we = 1'b1; bus.freq_in = f; bus.phase_off = ph;
      tick();
      idle();
      repeat (3) tick();
   endtask

   int s1_exp[4] = '{101, 32767, -101, -32767};
   int c1_exp[4] = '{32767, -101, -32767, 101};
   int en_pat[5] = '{1, 0, 1, 1, 0};
   int samp[1100];
   int ov[8];

   initial begin
      int n;
      int cnt;
      int bad;
      rst_n = 1'b0;
      idle();
      bus.freq_in = '0;
      bus.phase_off = '0;
      repeat (2) tick();
      check_lit("reset_valid", int'(bus.out_valid), 0);
      check_lit("reset_sin", s_out(), 0);
      check_lit("reset_cos", c_out(), 0);
      rst_n = 1'b1;
      tick();

      // Scenario 1: quarter-turn steps
      bus.freq_we = 1'b1; bus.freq_in = 32'h4000_0000;
      tick();
      bus.freq_we = 1'b0; bus.en = 1'b1;
      cnt = 0;
      while (!bus.out_valid && cnt < 10) begin
         tick();
         cnt++;
      end
      check_lit("s1_latency", cnt, 3);
      for (int k = 0; k < 8; k++) begin
         check_lit("s1_sin", s_out(), s1_exp[k % 4]);
         check_lit("s1_cos", c_out(), c1_exp[k % 4]);
         tick();
      end

      // Scenario 2: one index per clock, full period
      restart(32'h0040_0000, 32'h0);
      bus.en = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 1200 && n < 1100; cyc++) begin
         tick();
         if (bus.out_valid) begin
            samp[n] = s_out();
            n++;
         end
      end
      check_lit("s2_sample_count", n, 1100);
      check_lit("s2_peak255", samp[255], 32767);
      check_lit("s2_peak256", samp[256], 32767);
      check_lit("s2_trough767", samp[767], -32767);
      check_lit("s2_trough768", samp[768], -32767);
      check_lit("s2_first", samp[0], 101);
      bad = 0;
      for (int k = 0; k < 76; k++) if (samp[k] != samp[k + 1024]) bad++;
      check_lit("s2_period_mismatches", bad, 0);

      // Scenario 3: negative step, wraps on first sample
      restart(32'hFFC0_0000, 32'h0);
      bus.en = 1'b1;
      repeat (1100) tick();

      // Scenario 4: fixed phase offset, zero frequency
      restart(32'h0, 32'h4000_0000);
      bus.en = 1'b1;
      repeat (5) tick();
      for (int k = 0; k < 4; k++) begin
         check_lit("s4_sin", s_out(), 32767);
         check_lit("s4_cos", c_out(), -101);
         tick();
      end

      // Scenario 5: en pattern reproduced three clocks later
      restart(32'h0100_0000, 32'h0);
      bus.en = en_pat[0][0];
      for (int k = 0; k < 8; k++) begin
         tick();
         ov[k] = int'(bus.out_valid);
         bus.en = (k + 1 < 5) ? en_pat[k + 1][0] : 1'b0;
      end
      for (int j = 0; j < 5; j++) check_lit("s5_valid_pattern", ov[j + 2], en_pat[j]);

      // Scenario 6a: reset mid-stream
      restart(32'h0123_4567, 32'h0);
      bus.en = 1'b1;
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.en = 1'b0;
      check_lit("s6_rst_sin", s_out(), 0);
      check_lit("s6_rst_valid", int'(bus.out_valid), 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check_lit("s6_no_stale_valid", int'(bus.out_valid), 0);
      end
      bus.freq_we = 1'b1; bus.freq_in = 32'h0200_0000; bus.en = 1'b1;
      tick();
      bus.freq_we = 1'b0;
      repeat (10) tick();

      // Scenario 6b: sync_clr together with en and freq load
      bus.sync_clr = 1'b1; bus.freq_we = 1'b1; bus.freq_in = 32'h0300_0000;
      tick();
      bus.sync_clr = 1'b0; bus.freq_we = 1'b0;
      repeat (10) tick();

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         bus.en       = ($urandom_range(0, 9) < 7);
         bus.sync_clr = ($urandom_range(0, 99) < 3);
         bus.freq_we  = ($urandom_range(0, 9) == 0);
         bus.freq_in  = $urandom;
         if ($urandom_range(0, 9) == 0) bus.phase_off = $urandom;
         tick();
      end
      idle();
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
